// File: rtl/watch_mode_controller.sv
// Mode/set-time sequencer for the watch counter chain: button sync, run/pause/set FSM,
// hour/minute increment pulses and blink enables. Define WATCH_CTRL_AUTOREPEAT_EN for held-inc repeat.
module watch_mode_controller #(
    parameter int unsigned BLINK_DIV     = 25_000_000,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_startstop_i,
    output logic       count_en_o,
    output logic       min_inc_o,
    output logic       hr_inc_o,
    output logic       sec_clr_o,
    output logic       disp_hr_on_o,
    output logic       disp_min_on_o,
    output logic [1:0] mode_o
);
    typedef enum logic [1:0] {
        PAUSE   = 2'b00,
        RUN     = 2'b01,
        SET_HR  = 2'b10,
        SET_MIN = 2'b11
    } state_e;

    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

    if (BLINK_DIV < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_chk
        $error("watch_mode_controller: BLINK_DIV, HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    // Bit order for all button vectors: {mode, inc, startstop}
    logic [2:0]    btn_raw, s1_q, s2_q, s3_q, press;
    state_e        state_q, state_d;
    logic          hr_inc_q, hr_inc_d, min_inc_q, min_inc_d, sec_clr_q, sec_clr_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          rpt_fire;

    assign btn_raw = {btn_mode_i, btn_inc_i, btn_startstop_i};
    assign press   = s2_q & ~s3_q;

    // Reset loads the whole chain from the pin so a button held through reset is not a press
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= btn_raw;
            s2_q <= btn_raw;
            s3_q <= btn_raw;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        hr_inc_d  = 1'b0;
        min_inc_d = 1'b0;
        sec_clr_d = 1'b0;
        case (state_q)
            PAUSE: begin
                if (press[2])      state_d = SET_HR;
                else if (press[0]) state_d = RUN;
            end
            RUN: begin
                if (press[2])      state_d = SET_HR;
                else if (press[0]) state_d = PAUSE;
            end
            SET_HR: begin
                if (press[2])                  state_d = SET_MIN;
                else if (press[1] || rpt_fire) hr_inc_d = 1'b1;
            end
            default: begin
                if (press[2]) begin
                    state_d   = RUN;
                    sec_clr_d = 1'b1;
                end else if (press[1] || rpt_fire) begin
                    min_inc_d = 1'b1;
                end
            end
        endcase
    end

    // Blink restarts visible on every entry into a set state and on every increment
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_d != state_q || hr_inc_d || min_inc_d || !state_q[1]) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_TC) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= PAUSE;
            hr_inc_q    <= 1'b0;
            min_inc_q   <= 1'b0;
            sec_clr_q   <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            hr_inc_q    <= hr_inc_d;
            min_inc_q   <= min_inc_d;
            sec_clr_q   <= sec_clr_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

`ifdef WATCH_CTRL_AUTOREPEAT_EN
    localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_TC = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);

    logic          rpt_act_q, rpt_act_d, rpt_first_q, rpt_first_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;

    // rpt_cnt counts cycles since the last inc pulse; first interval is the hold time
    assign rpt_fire = rpt_act_q & s2_q[1] & (rpt_cnt_q == (rpt_first_q ? HOLD_TC : REP_TC));

    always_comb begin
        rpt_act_d   = rpt_act_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        if (state_d != state_q || !s2_q[1]) begin
            rpt_act_d   = 1'b0;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (press[1] && state_q[1]) begin
            rpt_act_d   = 1'b1;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (rpt_act_q) begin
            if (rpt_fire) begin
                rpt_first_d = 1'b0;
                rpt_cnt_d   = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rpt_act_q   <= 1'b0;
            rpt_first_q <= 1'b1;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign count_en_o    = tick_i & (state_q == RUN);
    assign min_inc_o     = min_inc_q;
    assign hr_inc_o      = hr_inc_q;
    assign sec_clr_o     = sec_clr_q;
    assign disp_hr_on_o  = (state_q != SET_HR) | phase_q;
    assign disp_min_on_o = (state_q != SET_MIN) | phase_q;
    assign mode_o        = state_q;
endmodule

// File: tb/tb_watch_mode_controller.sv
// Bench for watch_mode_controller: vector table, directed corner sequences and random stimulus
// compared every cycle against a cycle-age based reference model.
module tb_watch_mode_controller;
    localparam int BD = 4;
    localparam int HC = 8;
    localparam int RC = 3;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, b_mode = 1'b0, b_inc = 1'b0, b_ss = 1'b0;
    logic count_en, min_inc, hr_inc, sec_clr, disp_hr, disp_min;
    logic [1:0] mode;

    always #5 clk = ~clk;

    watch_mode_controller #(.BLINK_DIV(BD), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)) dut (
        .clk_i(clk), .reset_i(rst), .tick_i(tick), .btn_mode_i(b_mode), .btn_inc_i(b_inc),
        .btn_startstop_i(b_ss), .count_en_o(count_en), .min_inc_o(min_inc), .hr_inc_o(hr_inc),
        .sec_clr_o(sec_clr), .disp_hr_on_o(disp_hr), .disp_min_on_o(disp_min), .mode_o(mode)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: press detection from sample history, ages in cycles for blink/repeat
    logic [2:0] m_s1 = '0, m_s2 = '0, m_s3 = '0;
    logic [1:0] m_mode = '0;
    logic m_hr = 0, m_min = 0, m_clr = 0, m_ract = 0;
    int m_age = 0, m_rage = 0;

    always @(posedge clk) begin : ref_model
        logic [2:0] btn, pr;
        logic [1:0] nm;
        logic hr, mn, cl, fire;
        btn = {b_mode, b_inc, b_ss};
        if (rst) begin
            m_s1 <= btn; m_s2 <= btn; m_s3 <= btn;
            m_mode <= 2'd0; m_hr <= 0; m_min <= 0; m_clr <= 0;
            m_age <= 0; m_ract <= 0; m_rage <= 0;
        end else begin
            pr = m_s2 & ~m_s3;
            nm = m_mode; hr = 0; mn = 0; cl = 0; fire = 0;
`ifdef WATCH_CTRL_AUTOREPEAT_EN
            fire = m_ract && m_s2[1] &&
                   ((m_rage + 1 == HC) || (m_rage + 1 > HC && (m_rage + 1 - HC) % RC == 0));
`endif
            if (pr[2]) begin
                nm = (m_mode == 2'd2) ? 2'd3 : (m_mode == 2'd3) ? 2'd1 : 2'd2;
                cl = (m_mode == 2'd3);
            end else if (m_mode < 2'd2) begin
                if (pr[0]) nm = (m_mode == 2'd0) ? 2'd1 : 2'd0;
            end else if (pr[1] || fire) begin
                hr = (m_mode == 2'd2);
                mn = (m_mode == 2'd3);
            end
            m_mode <= nm; m_hr <= hr; m_min <= mn; m_clr <= cl;
            m_age <= (nm != m_mode || hr || mn) ? 0 : m_age + 1;
            if (nm != m_mode || !m_s2[1]) m_ract <= 0;
            else if (pr[1] && m_mode >= 2'd2) begin m_ract <= 1; m_rage <= 0; end
            else if (m_ract) m_rage <= m_rage + 1;
            m_s1 <= btn; m_s2 <= m_s1; m_s3 <= m_s2;
        end
    end

    function automatic logic [7:0] mdl_vec();
        logic dh, dm;
        dh = (m_mode != 2'd2) || ((m_age / BD) % 2 == 0);
        dm = (m_mode != 2'd3) || ((m_age / BD) % 2 == 0);
        return {tick && m_mode == 2'd1, m_min, m_hr, m_clr, dh, dm, m_mode};
    endfunction

    logic [7:0] dut_vec;
    assign dut_vec = {count_en, min_inc, hr_inc, sec_clr, disp_hr, disp_min, mode};

    int cyc = 0, n_hr = 0, n_min = 0, n_clr = 0;
    int minq[$];
    always @(posedge clk) begin
        #1;
        cyc++;
        chk("model", 32'(dut_vec), 32'(mdl_vec()));
        if (min_inc === 1'b1) minq.push_back(cyc);
        if (hr_inc === 1'b1) n_hr++;
        if (min_inc === 1'b1) n_min++;
        if (sec_clr === 1'b1) n_clr++;
    end

    typedef struct {
        logic       r, t, m, i, s;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic r, t, m, i, s, input logic [7:0] e);
        vec_t v;
        v.r = r; v.t = t; v.m = m; v.i = i; v.s = s; v.exp = e;
        vt.push_back(v);
    endtask

    task automatic set_btn(input int w, input logic v);
        case (w)
            0: b_ss = v;
            1: b_inc = v;
            default: b_mode = v;
        endcase
    endtask

    task automatic tap(input int w);
        set_btn(w, 1'b1);
        repeat (3) @(negedge clk);
        set_btn(w, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int b_hr, b_min, b_clr, base;
        int exp_gap[$];
        // Expected vector: {count_en, min_inc, hr_inc, sec_clr, disp_hr, disp_min, mode}
        add(1,0,0,0,0,8'h0C); add(1,1,0,0,0,8'h0C);
        add(0,0,0,0,1,8'h0C); add(0,0,0,0,1,8'h0C); add(0,1,0,0,1,8'h8D);
        add(0,0,0,0,0,8'h0D); add(0,1,0,0,0,8'h8D);
        add(0,0,0,0,1,8'h0D); add(0,0,0,0,1,8'h0D); add(0,1,0,0,0,8'h0C);
        add(0,0,1,0,0,8'h0C); add(0,0,1,0,0,8'h0C); add(0,0,0,0,0,8'h0E);
        add(0,0,0,1,0,8'h0E); add(0,0,0,1,0,8'h0E); add(0,0,0,0,0,8'h2E);
        add(0,0,0,0,0,8'h0E); add(0,0,0,0,0,8'h0E); add(0,0,0,0,0,8'h0E);
        add(0,0,0,0,0,8'h06);
        add(0,0,1,0,0,8'h06); add(0,0,1,0,0,8'h06); add(0,0,0,0,0,8'h0F);
        add(0,1,0,0,0,8'h0F); add(0,0,0,1,0,8'h0F); add(0,0,0,1,0,8'h0F);
        add(0,0,0,0,0,8'h4F);
        add(0,0,1,0,0,8'h0F); add(0,0,1,0,0,8'h0F); add(0,0,0,0,0,8'h1D);
        add(0,0,0,0,0,8'h0D);

        foreach (vt[k]) begin
            @(negedge clk);
            rst = vt[k].r; tick = vt[k].t; b_mode = vt[k].m; b_inc = vt[k].i; b_ss = vt[k].s;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", k), 32'(dut_vec), 32'(vt[k].exp));
        end
        @(negedge clk);
        rst = 0; tick = 0; b_mode = 0; b_inc = 0; b_ss = 0;

        // Full set sequence from RUN, startstop ignored in SET_HR
        do_reset();
        tap(0);
        chk("seq_run", 32'(mode), 32'd1);
        b_hr = n_hr; b_min = n_min; b_clr = n_clr;
        tap(2); tap(1); tap(1); tap(0);
        chk("ss_ignored", 32'(mode), 32'd2);
        tap(2); tap(1); tap(1); tap(1); tap(2);
        chk("hr_count", 32'(n_hr - b_hr), 32'd2);
        chk("min_count", 32'(n_min - b_min), 32'd3);
        chk("clr_count", 32'(n_clr - b_clr), 32'd1);
        chk("seq_end_mode", 32'(mode), 32'd1);

        // Blink pattern in idle SET_HR
        do_reset();
        b_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        b_mode = 1'b0;
        chk("blink_mode", 32'(mode), 32'd2);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("blink_hr%0d", k), 32'(disp_hr), 32'((k / 4) % 2 == 0));
            chk($sformatf("blink_min%0d", k), 32'(disp_min), 32'd1);
            @(posedge clk);
            #1;
        end

        // Mode and inc together in SET_HR: mode wins, inc dropped
        @(negedge clk);
        b_hr = n_hr;
        b_mode = 1'b1; b_inc = 1'b1;
        repeat (3) @(negedge clk);
        b_mode = 1'b0; b_inc = 1'b0;
        repeat (4) @(negedge clk);
        chk("simul_mode", 32'(mode), 32'd3);
        chk("simul_no_hr", 32'(n_hr - b_hr), 32'd0);

        // Held inc in SET_MIN
        do_reset();
        tap(2); tap(2);
        chk("hold_mode", 32'(mode), 32'd3);
        base = minq.size();
        b_inc = 1'b1;
        repeat (20) @(negedge clk);
        b_inc = 1'b0;
        repeat (10) @(negedge clk);
`ifdef WATCH_CTRL_AUTOREPEAT_EN
        exp_gap = '{0, 8, 11, 14, 17};
`else
        exp_gap = '{0};
`endif
        chk("rpt_count", 32'(minq.size() - base), 32'(exp_gap.size()));
        if (minq.size() - base == exp_gap.size())
            foreach (exp_gap[k])
                chk($sformatf("rpt_gap%0d", k), 32'(minq[base + k] - minq[base]), 32'(exp_gap[k]));

        // Reset while inc held mid-blink in SET_MIN
        b_inc = 1'b1;
        repeat (9) @(negedge clk);
        b_min = n_min;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid", 32'(dut_vec), 32'h0C);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_hold_no_min", 32'(n_min - b_min), 32'd0);
        chk("rst_hold_mode", 32'(mode), 32'd0);
        b_inc = 1'b0;

        // Random stimulus against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst  = ($urandom_range(199) == 0);
            tick = ($urandom_range(5) == 0);
            if ($urandom_range(9) == 0)  b_mode = ~b_mode;
            if ($urandom_range(11) == 0) b_inc = ~b_inc;
            if ($urandom_range(7) == 0)  b_ss = ~b_ss;
        end
        @(negedge clk);
        rst = 0; tick = 0; b_mode = 0; b_inc = 0; b_ss = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
